// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use
// stall, branch flush, multi-cycle execute stall and saturating perf counters.
//
// state  | meaning
// S_IDLE | no multi-cycle op in flight; a new one may start from Execute
// S_BUSY | multi-cycle op occupying Execute; cnt = remaining stall cycles
module hazard_ctrl_unit #(
  parameter int REG_AW    = 5,
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MultiE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic              ExDone,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int CW = $clog2(MULTI_LAT) + 1;
  // The first stall cycle is spent in IDLE, so BUSY counts the remaining ones
  // down to zero and finishes on the zero cycle.
  localparam logic [CW-1:0] CNT_LOAD = (MULTI_LAT > 1) ? CW'(MULTI_LAT - 2) : '0;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          m_stall, ex_done, lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RD_M != '0) && (RD_M == rs))      fwd_sel = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == rs)) fwd_sel = 2'b01;
    else                                                fwd_sel = 2'b00;
  endfunction

  assign lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // State and down-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Multi-cycle sequencing; a taken branch always cancels the op.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    m_stall   = 1'b0;
    ex_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (MultiE && !PCSrcE) begin
          if (MULTI_LAT > 1) begin
            m_stall   = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = S_BUSY;
          end else begin
            ex_done = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (PCSrcE) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          m_stall = 1'b1;
          cnt_nxt = cnt - CW'(1);
        end else begin
          ex_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Prioritised pipeline controls; everything reads 0 while reset is held.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    BubbleM   = 1'b0;
    ExDone    = 1'b0;
    if (rst) begin
      ForwardAE = fwd_sel(Rs1_E);
      ForwardBE = fwd_sel(Rs2_E);
      ExDone    = ex_done;
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (m_stall) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        BubbleM = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
      if (PCSrcE && (FlushCount != '1)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule
